// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, decoder FSM encoding and a saturating
// counter helper, used by both the VGA timing generator and the sync decoder.
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned GOOD_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_e;

  // Increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Sampled edge detector: holds the previous strobed sample of d and flags
// falling/rising transitions on strobe cycles.
// Ports: clk, rst (async active-low), en (sample strobe), d (input),
//        fall_c / rise_c (combinational edge flags, valid while en=1).
module vga_edge_det #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic fall_c,
  output logic rise_c
);

  logic prev;

  // Previous-sample register, only advances on strobed samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev <= RESET_VAL;
    end else if (en) begin
      prev <= d;
    end
  end

  assign fall_c = en & prev & ~d;
  assign rise_c = en & ~prev & d;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates from
// hsync/vsync/de, measures line and frame periods and tracks lock.
// Ports: clk, rst (async active-low), pix_en (sample strobe), hsync_n,
//        vsync_n, de in; x_pos, y_pos, pix_valid, line_start, frame_start,
//        locked, h_meas, v_meas, line_err, frame_err out (all registered).
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
  parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             hsync_n,
  input  logic             vsync_n,
  input  logic             de,
  output logic [CNT_W-1:0] x_pos,
  output logic [CNT_W-1:0] y_pos,
  output logic             pix_valid,
  output logic             line_start,
  output logic             frame_start,
  output logic             locked,
  output logic [CNT_W-1:0] h_meas,
  output logic [CNT_W-1:0] v_meas,
  output logic             line_err,
  output logic             frame_err
);

  // h_cnt stepping from here onto CNT_MAX means the line never ended.
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_MAX - CNT_W'(1);

  sync_state_e       state, state_next;
  logic [GOOD_W-1:0] good_cnt, good_next, good_inc;
  logic [CNT_W-1:0]  h_cnt, v_cnt, de_lines, de_lines_c;
  logic              h_seen, err_seen;

  logic             hs_fall_c, vs_fall_c, de_rise_c, de_fall_c;
  logic             hs_rise_unused, vs_rise_unused;
  logic [CNT_W:0]   h_period_c, de_run_c;
  logic             line_err_c, frame_good_c, frame_err_c, timeout_c;

  vga_edge_det #(.RESET_VAL(1'b1)) u_hs_edge (
    .clk(clk), .rst(rst), .en(pix_en), .d(hsync_n),
    .fall_c(hs_fall_c), .rise_c(hs_rise_unused)
  );

  vga_edge_det #(.RESET_VAL(1'b1)) u_vs_edge (
    .clk(clk), .rst(rst), .en(pix_en), .d(vsync_n),
    .fall_c(vs_fall_c), .rise_c(vs_rise_unused)
  );

  vga_edge_det #(.RESET_VAL(1'b0)) u_de_edge (
    .clk(clk), .rst(rst), .en(pix_en), .d(de),
    .fall_c(de_fall_c), .rise_c(de_rise_c)
  );

  // Line and de-run checks; x_pos holds the last high sample's index at the de fall.
  assign h_period_c = {1'b0, h_cnt} + (CNT_W+1)'(1);
  assign de_run_c   = {1'b0, x_pos} + (CNT_W+1)'(1);
  assign line_err_c = (hs_fall_c && h_seen && (h_period_c != (CNT_W+1)'(H_TOTAL)))
                    || (de_fall_c && (de_run_c != (CNT_W+1)'(H_ACTIVE)));

  // Frame verdict includes events landing on the vsync sample itself.
  assign de_lines_c   = de_fall_c ? sat_inc(de_lines) : de_lines;
  assign frame_good_c = (v_cnt == CNT_W'(V_TOTAL)) && (de_lines_c == CNT_W'(V_ACTIVE))
                      && !err_seen && !line_err_c;

  assign timeout_c = pix_en && !hs_fall_c && (h_cnt >= TIMEOUT_AT);
  assign good_inc  = good_cnt + GOOD_W'(1);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
    end
  end

  // FSM next state; timeout overrides any vsync decision.
  always_comb begin
    state_next  = state;
    good_next   = good_cnt;
    frame_err_c = 1'b0;
    if (timeout_c) begin
      state_next = SEARCH;
      good_next  = '0;
    end else if (vs_fall_c) begin
      unique case (state)
        SEARCH: begin
          state_next = ACQUIRE;
          good_next  = '0;
        end
        ACQUIRE: begin
          if (frame_good_c) begin
            good_next = good_inc;
            if (good_inc == GOOD_W'(LOCK_FRAMES)) state_next = LOCKED;
          end else begin
            good_next = '0;
          end
        end
        LOCKED: begin
          if (!frame_good_c) begin
            frame_err_c = 1'b1;
            state_next  = ACQUIRE;
            good_next   = '0;
          end
        end
        default: begin
          state_next = SEARCH;
          good_next  = '0;
        end
      endcase
    end
  end

  // Counters, measurements and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      de_lines    <= '0;
      h_seen      <= 1'b0;
      err_seen    <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      h_meas      <= '0;
      v_meas      <= '0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      line_start  <= hs_fall_c;
      frame_start <= vs_fall_c;
      line_err    <= line_err_c;
      frame_err   <= frame_err_c;
      locked      <= (state_next == LOCKED);
      if (pix_en) begin
        pix_valid <= de;
        h_cnt     <= hs_fall_c ? '0 : sat_inc(h_cnt);
        if (timeout_c)      h_seen <= 1'b0;
        else if (hs_fall_c) h_seen <= 1'b1;
        if (hs_fall_c && h_seen) h_meas <= h_period_c[CNT_W-1:0];
        // A coincident hsync edge belongs to the new frame.
        if (vs_fall_c) begin
          v_meas <= v_cnt;
          v_cnt  <= hs_fall_c ? CNT_W'(1) : '0;
        end else if (hs_fall_c) begin
          v_cnt <= sat_inc(v_cnt);
        end
        if (de_rise_c) x_pos <= '0;
        else if (de)   x_pos <= sat_inc(x_pos);
        if (vs_fall_c)      y_pos <= '0;
        else if (de_fall_c) y_pos <= sat_inc(y_pos);
        de_lines <= vs_fall_c ? '0 : de_lines_c;
        if (vs_fall_c)       err_seen <= 1'b0;
        else if (line_err_c) err_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced 40x12 raster so whole
// frames fit in a short run; pix_en runs at half the clock rate.
module tb_vga_sync_decoder;

  localparam int T_H_ACTIVE = 32;
  localparam int T_H_FP     = 2;
  localparam int T_H_SYNC   = 4;
  localparam int T_H_TOTAL  = 40;
  localparam int T_V_ACTIVE = 8;
  localparam int T_V_FP     = 1;
  localparam int T_V_SYNC   = 2;
  localparam int T_V_TOTAL  = 12;
  localparam int HS_START   = T_H_ACTIVE + T_H_FP;
  localparam int VS_START   = T_V_ACTIVE + T_V_FP;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pix_en = 1'b0;
  logic hsync_n = 1'b1;
  logic vsync_n = 1'b1;
  logic de = 1'b0;
  logic [9:0] x_pos, y_pos, h_meas, v_meas;
  logic pix_valid, line_start, frame_start, locked, line_err, frame_err;

  vga_sync_decoder #(
    .H_TOTAL(T_H_TOTAL), .V_TOTAL(T_V_TOTAL),
    .H_ACTIVE(T_H_ACTIVE), .V_ACTIVE(T_V_ACTIVE), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de),
    .x_pos(x_pos), .y_pos(y_pos), .pix_valid(pix_valid),
    .line_start(line_start), .frame_start(frame_start), .locked(locked),
    .h_meas(h_meas), .v_meas(v_meas), .line_err(line_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Stream position and per-frame modifiers.
  int gv = 0;
  int gh = 0;
  int stretch_line = -1;
  int short_de_line = -1;
  logic coinc = 1'b0;

  // Observations.
  int fr_le, fr_fe, fr_ls, fr_fs, le_v, le_h;
  int cap_x0, cap_y0, cap_pv0, cap_x1, cap_y1, cap_y3, cap_hmeas5;
  int vs_idx = 0;
  int lock_after [16];
  int pulse_stuck = 0;
  logic prev_vs = 1'b1;
  int lost_at;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic reset_stats();
    fr_le = 0; fr_fe = 0; fr_ls = 0; fr_fs = 0; le_v = -1; le_h = -1;
  endtask

  // One strobed sample followed by one idle clock.
  task automatic step(input logic hs, input logic vs, input logic d);
    hsync_n = hs; vsync_n = vs; de = d; pix_en = 1'b1;
    @(negedge clk);
    if (line_err) begin fr_le++; le_v = gv; le_h = gh; end
    fr_fe += int'(frame_err);
    fr_ls += int'(line_start);
    fr_fs += int'(frame_start);
    if (prev_vs && !vs) begin
      if (vs_idx < 16) lock_after[vs_idx] = int'(locked);
      vs_idx++;
    end
    prev_vs = vs;
    pix_en = 1'b0;
    @(negedge clk);
    if (line_start || frame_start || line_err || frame_err) pulse_stuck++;
  endtask

  task automatic gen_sample();
    logic hs, vs, d;
    int de_len, len;
    de_len = (gv == short_de_line) ? T_H_ACTIVE - 1 : T_H_ACTIVE;
    len    = (gv == stretch_line) ? T_H_TOTAL + 1 : T_H_TOTAL;
    d  = (gv < T_V_ACTIVE) && (gh < de_len);
    hs = !((gh >= HS_START) && (gh < HS_START + T_H_SYNC));
    if (coinc)
      vs = !(((gv == VS_START) && (gh >= HS_START)) ||
             ((gv > VS_START) && (gv < VS_START + T_V_SYNC)) ||
             ((gv == VS_START + T_V_SYNC) && (gh < HS_START)));
    else
      vs = !((gv >= VS_START) && (gv < VS_START + T_V_SYNC));
    step(hs, vs, d);
    if (gv == 0 && gh == 0) begin
      cap_x0 = int'(x_pos); cap_y0 = int'(y_pos); cap_pv0 = int'(pix_valid);
    end
    if (gv == T_V_ACTIVE - 1 && gh == T_H_ACTIVE - 1) begin
      cap_x1 = int'(x_pos); cap_y1 = int'(y_pos);
    end
    if (gv == 3 && gh == 0) cap_y3 = int'(y_pos);
    if (gv == 5 && gh == 0) cap_hmeas5 = int'(h_meas);
    gh++;
    if (gh == len) begin
      gh = 0;
      gv++;
      if (gv == T_V_TOTAL) gv = 0;
    end
  endtask

  task automatic run_frame();
    gen_sample();
    while (!(gv == 0 && gh == 0)) gen_sample();
  endtask

  task automatic run_to(input int v, input int h);
    while (!(gv == v && gh == h)) gen_sample();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_x_pos"}, int'(x_pos), 0);
    check_eq({tag, "_y_pos"}, int'(y_pos), 0);
    check_eq({tag, "_h_meas"}, int'(h_meas), 0);
    check_eq({tag, "_v_meas"}, int'(v_meas), 0);
    check_eq({tag, "_locked"}, int'(locked), 0);
    check_eq({tag, "_flags"},
             int'({pix_valid, line_start, frame_start, line_err, frame_err}), 0);
  endtask

  initial begin
    // Reset state, then lock from a clean frame start.
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    reset_stats();
    repeat (3) run_frame();
    check_eq("init_locked", int'(locked), 1);

    // Mid-line reset, then SEARCH + two good frames.
    run_frame();
    run_to(3, 15);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b1;
    vs_idx = 0;
    repeat (3) run_frame();
    check_eq("midrst_vs_count", vs_idx, 3);
    check_eq("midrst_lock_vs1", lock_after[0], 0);
    check_eq("midrst_lock_vs2", lock_after[1], 0);
    check_eq("midrst_lock_vs3", lock_after[2], 1);

    // Coordinate tracking on a locked frame.
    reset_stats();
    run_frame();
    check_eq("coord_x_first", cap_x0, 0);
    check_eq("coord_y_first", cap_y0, 0);
    check_eq("coord_pix_valid", cap_pv0, 1);
    check_eq("coord_x_last", cap_x1, T_H_ACTIVE - 1);
    check_eq("coord_y_last", cap_y1, T_V_ACTIVE - 1);
    check_eq("coord_y_line3", cap_y3, 3);
    check_eq("coord_h_meas", int'(h_meas), T_H_TOTAL);
    check_eq("coord_v_meas", int'(v_meas), T_V_TOTAL);
    check_eq("coord_line_starts", fr_ls, T_V_TOTAL);
    check_eq("coord_frame_starts", fr_fs, 1);
    check_eq("coord_line_errs", fr_le, 0);
    check_eq("coord_frame_errs", fr_fe, 0);
    check_eq("coord_locked", int'(locked), 1);

    // Line 3 stretched by one sample.
    stretch_line = 3;
    reset_stats();
    run_frame();
    stretch_line = -1;
    check_eq("long_line_err_cnt", fr_le, 1);
    check_eq("long_line_err_line", le_v, 4);
    check_eq("long_line_err_col", le_h, HS_START);
    check_eq("long_h_meas", cap_hmeas5, T_H_TOTAL + 1);
    check_eq("long_frame_err_cnt", fr_fe, 1);
    check_eq("long_locked_drop", int'(locked), 0);
    run_frame();
    check_eq("long_relock_1", int'(locked), 0);
    run_frame();
    check_eq("long_relock_2", int'(locked), 1);

    // Line 2 de run one sample short.
    short_de_line = 2;
    reset_stats();
    run_frame();
    short_de_line = -1;
    check_eq("short_de_err_cnt", fr_le, 1);
    check_eq("short_de_err_line", le_v, 2);
    check_eq("short_de_err_col", le_h, T_H_ACTIVE - 1);
    check_eq("short_de_y_inc", cap_y3, 3);
    check_eq("short_de_frame_err", fr_fe, 1);
    repeat (2) run_frame();
    check_eq("short_de_relock", int'(locked), 1);

    // Loss of sync: hsync held high; last edge left h_cnt at 5 after the frame.
    reset_stats();
    lost_at = -1;
    for (int k = 1; k <= 1100; k++) begin
      step(1'b1, 1'b1, 1'b0);
      if (lost_at < 0 && !locked) lost_at = k;
    end
    check_eq("loss_drop_sample", lost_at, 1018);
    check_eq("loss_frame_err", fr_fe, 0);
    vs_idx = 0;
    repeat (3) run_frame();
    check_eq("loss_lock_vs1", lock_after[0], 0);
    check_eq("loss_lock_vs2", lock_after[1], 0);
    check_eq("loss_lock_vs3", lock_after[2], 1);

    // vsync falling together with hsync for two frames.
    coinc = 1'b1;
    reset_stats();
    repeat (2) run_frame();
    coinc = 1'b0;
    check_eq("coinc_v_meas", int'(v_meas), T_V_TOTAL);
    check_eq("coinc_frame_err", fr_fe, 0);
    check_eq("coinc_frame_starts", fr_fs, 2);
    check_eq("coinc_locked", int'(locked), 1);
    run_frame();
    check_eq("coinc_after_v_meas", int'(v_meas), T_V_TOTAL);
    check_eq("coinc_after_locked", int'(locked), 1);

    check_eq("pulses_idle_low", pulse_stuck, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
